// File: rtl/sprite_pkg.sv
// Shared types and screen constants for the sprite blit read path.
package sprite_pkg;

    typedef logic [23:0] pixel_t;
    typedef logic [18:0] fb_addr_t;

    localparam int unsigned SCR_W     = 640;
    localparam int unsigned SCR_H     = 480;
    localparam pixel_t      KEY_COLOR = 24'hFF00FF;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } blit_state_t;

    typedef struct packed {
        fb_addr_t addr;
        pixel_t   data;
    } px_entry_t;

endpackage

// File: rtl/blit_skid_fifo.sv
// Two-entry skid FIFO holding framebuffer address + colour for the pixel stream.
module blit_skid_fifo
    import sprite_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push_i,
    input  px_entry_t push_data_i,
    input  logic      pop_i,
    output px_entry_t head_o,
    output logic      full_o,
    output logic      empty_o,
    output logic [1:0] count_o
);

    px_entry_t  mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] cnt_q;
    logic [1:0] cnt_d;
    logic       push_ok_c;
    logic       pop_ok_c;

    assign empty_o = (cnt_q == 2'd0);
    assign full_o  = (cnt_q == 2'd2);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is accepted when the head leaves in the same cycle.
    assign pop_ok_c  = pop_i & ~empty_o;
    assign push_ok_c = push_i & (~full_o | pop_ok_c);

    always_comb begin
        cnt_d = cnt_q;
        if (push_ok_c && !pop_ok_c) begin
            cnt_d = cnt_q + 2'd1;
        end else if (!push_ok_c && pop_ok_c) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_ok_c) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_ok_c) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sprite_blit_reader.sv
// Walks one sprite frame from ROM and streams clipped pixels to the framebuffer writer.
// Optional SPRITE_BLIT_TRANSPARENT_EN drops pixels equal to KEY_COLOR.
module sprite_blit_reader
    import sprite_pkg::*;
#(
    parameter int unsigned SPR_W      = 38,
    parameter int unsigned SPR_H      = 30,
    parameter int unsigned NUM_FRAMES = 1,
    parameter int unsigned ADDR_W     = 19,
    parameter int unsigned DATA_W     = 24
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              start,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic [3:0]        frame_sel,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              px_valid,
    input  logic              px_ready,
    output logic [ADDR_W-1:0] px_addr,
    output logic [DATA_W-1:0] px_data
);

    localparam int unsigned FRAME_WORDS = SPR_W * SPR_H;
    localparam int unsigned COL_W       = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int unsigned ROW_W       = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam int unsigned CRD_W       = 11;

    blit_state_t        state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [CRD_W-1:0]   x_q, x_d;
    logic [CRD_W-1:0]   y_q, y_d;
    logic [CRD_W-1:0]   pos_x_q, pos_x_d;
    fb_addr_t           line_q, line_d;
    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    logic               ret_q, ret_d;
    logic               ret_vis_q, ret_vis_d;
    fb_addr_t           ret_fb_q, ret_fb_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               issue_c;
    logic               keep_c;
    logic               push_c;
    logic               pop_c;
    logic [2:0]         level_c;
    logic [2:0]         after_c;
    logic [ADDR_W-1:0]  frame_base_c;

    px_entry_t          fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic [1:0]         fifo_count;

`ifdef SPRITE_BLIT_TRANSPARENT_EN
    assign keep_c = ret_vis_q & (pixel_t'(rom_data) != KEY_COLOR);
`else
    assign keep_c = ret_vis_q;
`endif

    assign pop_c  = ~fifo_empty & px_ready;
    assign push_c = ret_q & keep_c & (~fifo_full | pop_c);

    // Occupancy net of this cycle's pop plus the read now returning; a new read may
    // only be issued if its data is guaranteed a FIFO slot next cycle.
    assign level_c = 3'(fifo_count) + 3'(ret_q) - 3'(pop_c);
    assign after_c = 3'(fifo_count) + 3'(push_c) - 3'(pop_c);

    assign frame_base_c = (32'(frame_sel) < NUM_FRAMES)
                        ? ADDR_W'(frame_sel) * ADDR_W'(FRAME_WORDS)
                        : '0;

    // Next-state, address walk and read issue.
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        x_d        = x_q;
        y_d        = y_q;
        pos_x_d    = pos_x_q;
        line_d     = line_q;
        rom_addr_d = rom_addr_q;
        ret_fb_d   = ret_fb_q;
        ret_vis_d  = 1'b0;
        issue_c    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = FETCH;
                    pos_x_d    = CRD_W'(pos_x);
                    x_d        = CRD_W'(pos_x);
                    y_d        = CRD_W'(pos_y);
                    line_d     = fb_addr_t'(pos_y) * fb_addr_t'(SCR_W);
                    rom_addr_d = frame_base_c;
                    col_d      = '0;
                    row_d      = '0;
                end
            end
            FETCH: begin
                if (level_c < 3'd2) begin
                    issue_c    = 1'b1;
                    rom_addr_d = rom_addr_q + ADDR_W'(1);
                    ret_fb_d   = line_q + fb_addr_t'(x_q);
                    ret_vis_d  = (x_q < CRD_W'(SCR_W)) && (y_q < CRD_W'(SCR_H));
                    if (col_q == COL_W'(SPR_W - 1)) begin
                        col_d  = '0;
                        x_d    = pos_x_q;
                        y_d    = y_q + CRD_W'(1);
                        line_d = line_q + fb_addr_t'(SCR_W);
                        if (row_q == ROW_W'(SPR_H - 1)) begin
                            state_d = DRAIN;
                        end else begin
                            row_d = row_q + ROW_W'(1);
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                        x_d   = x_q + CRD_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (after_c == 3'd0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ret_d  = issue_c;
        busy_d = (state_d == FETCH) || (state_d == DRAIN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            col_q      <= '0;
            row_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            pos_x_q    <= '0;
            line_q     <= '0;
            rom_addr_q <= '0;
            ret_q      <= 1'b0;
            ret_vis_q  <= 1'b0;
            ret_fb_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            x_q        <= x_d;
            y_q        <= y_d;
            pos_x_q    <= pos_x_d;
            line_q     <= line_d;
            rom_addr_q <= rom_addr_d;
            ret_q      <= ret_d;
            ret_vis_q  <= ret_vis_d;
            ret_fb_q   <= ret_fb_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    blit_skid_fifo u_skid (
        .clk         (Clk),
        .rst_n       (Reset_n),
        .push_i      (push_c),
        .push_data_i ('{addr: ret_fb_q, data: pixel_t'(rom_data)}),
        .pop_i       (pop_c),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign busy     = busy_q;
    assign done     = done_q;
    assign rom_addr = rom_addr_q;
    assign px_valid = ~fifo_empty;
    assign px_addr  = ADDR_W'(fifo_head.addr);
    assign px_data  = DATA_W'(fifo_head.data);

endmodule

// File: tb/tb_sprite_blit_reader.sv
// Randomized self-checking bench for sprite_blit_reader against a frame-walk reference model.
module tb_sprite_blit_reader;

    localparam int SW   = 38;
    localparam int SH   = 30;
    localparam int NF   = 3;
    localparam int FW   = SW * SH;
    localparam int NROM = NF * FW;
    localparam logic [23:0] KEY = 24'hFF00FF;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  pos_x = '0;
    logic [9:0]  pos_y = '0;
    logic [3:0]  frame_sel = '0;
    logic        busy;
    logic        done;
    logic [18:0] rom_addr;
    logic [23:0] rom_data = '0;
    logic        px_valid;
    logic        px_ready = 1'b0;
    logic [18:0] px_addr;
    logic [23:0] px_data;

    int total = 0;
    int bad   = 0;

    logic [23:0] rom [NROM];

    sprite_blit_reader #(
        .SPR_W      (SW),
        .SPR_H      (SH),
        .NUM_FRAMES (NF),
        .ADDR_W     (19),
        .DATA_W     (24)
    ) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .start     (start),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .frame_sel (frame_sel),
        .busy      (busy),
        .done      (done),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .px_valid  (px_valid),
        .px_ready  (px_ready),
        .px_addr   (px_addr),
        .px_data   (px_data)
    );

    always #5 Clk = ~Clk;

    // Synchronous ROM: data for the address presented in one cycle appears the next.
    always @(posedge Clk) begin
        rom_data <= (int'(rom_addr) < NROM) ? rom[int'(rom_addr)] : 24'h0;
    end

    task automatic check(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill_rom(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            do rom[i] = 24'($urandom); while (rom[i] == KEY);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},     longint'(busy), 0);
        check({tag, "_done"},     longint'(done), 0);
        check({tag, "_px_valid"}, longint'(px_valid), 0);
        check({tag, "_rom_addr"}, longint'(rom_addr), 0);
        check({tag, "_px_addr"},  longint'(px_addr), 0);
        check({tag, "_px_data"},  longint'(px_data), 0);
    endtask

    // rmode: 0 ready always, 1 pattern 1,0,0,1, 2 random. stop_after>0 aborts after that many pixels.
    task automatic run_blit(input int px, input int py, input int fr, input int rmode,
                            input int stop_after, input bit poke_busy, input bit poke_done,
                            input string tag,
                            output int npix, output int nvalid, output int nseen,
                            output int lat, output int ndone,
                            output int first_a, output int first_d, output int last_a);
        logic [42:0] expq[$];
        logic [42:0] e;
        bit          seen [FW];
        int          base, nexp, x, y;
        bit          stalled, aborted, keep;
        logic [18:0] hold_a;
        logic [23:0] hold_d;
        int          done_cyc;

        base = (fr < NF) ? fr * FW : 0;
        for (int r = 0; r < SH; r++) begin
            for (int c = 0; c < SW; c++) begin
                x = px + c;
                y = py + r;
                keep = (x < 640) && (y < 480);
`ifdef SPRITE_BLIT_TRANSPARENT_EN
                if (rom[base + r * SW + c] == KEY) keep = 1'b0;
`endif
                if (keep) expq.push_back({19'(y * 640 + x), rom[base + r * SW + c]});
            end
        end
        nexp = expq.size();
        foreach (seen[i]) seen[i] = 1'b0;
        npix = 0; nvalid = 0; nseen = 0; ndone = 0; lat = -1;
        first_a = -1; first_d = -1; last_a = -1;
        stalled = 1'b0; aborted = 1'b0; done_cyc = -1;
        hold_a = '0; hold_d = '0;

        start = 1'b1; pos_x = 10'(px); pos_y = 10'(py); frame_sel = 4'(fr);
        @(posedge Clk); #1;
        start = 1'b0; pos_x = 10'($urandom); pos_y = 10'($urandom); frame_sel = 4'($urandom);
        check({tag, "_busy_after_start"}, longint'(busy), 1);

        for (int cyc = 1; cyc < 6000; cyc++) begin
            if (busy && int'(rom_addr) >= base && int'(rom_addr) < base + FW) begin
                if (!seen[int'(rom_addr) - base]) begin
                    seen[int'(rom_addr) - base] = 1'b1;
                    nseen++;
                end
            end
            case (rmode)
                0:       px_ready = 1'b1;
                1:       px_ready = (((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3);
                default: px_ready = ($urandom_range(0, 9) < 6);
            endcase
            if (stalled) begin
                check({tag, "_stall_valid"}, longint'(px_valid), 1);
                check({tag, "_stall_addr"},  longint'(px_addr), longint'(hold_a));
                check({tag, "_stall_data"},  longint'(px_data), longint'(hold_d));
            end
            if (px_valid) nvalid++;
            if (px_valid && px_ready) begin
                if (expq.size() == 0) begin
                    check({tag, "_extra_pixel"}, 1, 0);
                end else begin
                    e = expq.pop_front();
                    check({tag, "_px_addr"}, longint'(px_addr), longint'(e[42:24]));
                    check({tag, "_px_data"}, longint'(px_data), longint'(e[23:0]));
                end
                if (npix == 0) begin
                    first_a = int'(px_addr);
                    first_d = int'(px_data);
                end
                last_a = int'(px_addr);
                npix++;
            end
            stalled = px_valid && !px_ready;
            hold_a  = px_addr;
            hold_d  = px_data;
            if (done_cyc >= 0) check({tag, "_busy_after_done"}, longint'(busy), 0);
            if (done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = cyc;
                if (poke_done) begin
                    start = 1'b1; pos_x = 10'd0; pos_y = 10'd0; frame_sel = 4'd0;
                end
            end
            if (poke_busy && cyc == 20) begin
                start = 1'b1; pos_x = 10'd3; pos_y = 10'd3; frame_sel = 4'd1;
            end
            if (stop_after > 0 && npix == stop_after) begin
                aborted = 1'b1;
                break;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
            @(posedge Clk); #1;
            start = 1'b0;
        end

        lat = done_cyc;
        if (!aborted) begin
            check({tag, "_timeout"}, longint'(done_cyc >= 0), 1);
            check({tag, "_pixel_count"}, npix, nexp);
            check({tag, "_model_left"}, expq.size(), 0);
            check({tag, "_done_pulses"}, ndone, 1);
            check({tag, "_rom_reads"}, nseen, FW);
        end
    endtask

    int npix, nvalid, nseen, lat, ndone, fa, fd, la, cnt, idx;

    initial begin
        fill_rom(0, NROM);

        Reset_n = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check_reset_outputs("reset");
        Reset_n = 1'b1;
        @(posedge Clk); #1;

        run_blit(100, 50, 0, 0, 0, 1'b0, 1'b1, "basic", npix, nvalid, nseen, lat, ndone, fa, fd, la);
        check("basic_count", npix, 1140);
        check("basic_first_addr", fa, 32100);
        check("basic_first_data", fd, longint'(rom[0]));
        check("basic_last_addr", la, 50697);
        check("basic_latency_ok", longint'(lat <= 1144), 1);

        run_blit(100, 50, 0, 1, 0, 1'b1, 1'b0, "backpressure", npix, nvalid, nseen, lat, ndone, fa, fd, la);
        check("bp_count", npix, 1140);

        run_blit(620, 0, 0, 0, 0, 1'b0, 1'b0, "right_clip", npix, nvalid, nseen, lat, ndone, fa, fd, la);
        check("clip_count", npix, 600);

        run_blit(700, 500, 0, 0, 0, 1'b0, 1'b0, "offscreen", npix, nvalid, nseen, lat, ndone, fa, fd, la);
        check("off_valid_cycles", nvalid, 0);
        check("off_reads", nseen, 1140);
        check("off_done", ndone, 1);

        run_blit(2, 470, 2, 2, 0, 1'b1, 1'b0, "frame2", npix, nvalid, nseen, lat, ndone, fa, fd, la);
        run_blit(0, 0, 9, 2, 0, 1'b0, 1'b1, "frame_oob", npix, nvalid, nseen, lat, ndone, fa, fd, la);
        check("frame_oob_first_data", fd, longint'(rom[0]));

        run_blit(100, 50, 0, 0, 200, 1'b0, 1'b0, "rst_pre", npix, nvalid, nseen, lat, ndone, fa, fd, la);
        check("rst_pre_pixels", npix, 200);
        Reset_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk); #1;
            check("mid_reset_no_done", longint'(done), 0);
        end
        Reset_n = 1'b1;
        @(posedge Clk); #1;
        run_blit(100, 50, 0, 0, 0, 1'b0, 1'b0, "rst_post", npix, nvalid, nseen, lat, ndone, fa, fd, la);
        check("rst_post_count", npix, 1140);

        for (int t = 0; t < 6; t++) begin
            int rx, ry;
            rx = (t % 2 == 0) ? $urandom_range(600, 660) : $urandom_range(0, 1023);
            ry = (t % 3 == 0) ? $urandom_range(440, 500) : $urandom_range(0, 1023);
            run_blit(rx, ry, $urandom_range(0, 15), 2, 0, 1'(t % 2), 1'(t % 3 == 1), "random",
                     npix, nvalid, nseen, lat, ndone, fa, fd, la);
        end

        cnt = 0;
        while (cnt < 300) begin
            idx = $urandom_range(0, FW - 1);
            if (rom[idx] != KEY) begin
                rom[idx] = KEY;
                cnt++;
            end
        end
        run_blit(100, 50, 0, 2, 0, 1'b0, 1'b0, "transparent", npix, nvalid, nseen, lat, ndone, fa, fd, la);
`ifdef SPRITE_BLIT_TRANSPARENT_EN
        check("transparent_count", npix, 840);
`else
        check("transparent_count", npix, 1140);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sprite_blit_reader.md
Name: sprite_blit_reader

Overview:
- Read-side initiator for the 24-bit sprite ROMs, such as the duck sprite ROM with 1140 words (38x30).
- On a start pulse, walks one sprite frame row-major and issues ROM addresses.
- Absorbs the ROM's fixed 1-cycle read latency.
- Emits a valid/ready pixel stream (framebuffer address + colour) to the framebuffer writer, clipping pixels outside the 640x480 screen.

Parameters:
- SPR_W, 38, sprite width in pixels
- SPR_H, 30, sprite height in pixels
- NUM_FRAMES, 1, animation frames stored back-to-back in the ROM
- ADDR_W, 19, ROM and framebuffer address width
- DATA_W, 24, pixel colour width (RGB888)
- SCR_W, 640, screen width; also the framebuffer stride
- SCR_H, 480, screen height
- KEY_COLOR, 24'hFF00FF, transparent colour key

Ports:
- Clk  in  1  system clock, all logic on posedge
- Reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to blit; ignored while busy
- pos_x  in  10  sprite top-left X on screen, sampled at start
- pos_y  in  10  sprite top-left Y on screen, sampled at start
- frame_sel  in  4  animation frame index, sampled at start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the blit is complete
- rom_addr  out  ADDR_W  read address to the sprite ROM
- rom_data  in  DATA_W  ROM data, valid exactly 1 cycle after rom_addr
- px_valid  out  1  pixel-stream valid
- px_ready  in  1  pixel-stream ready from the framebuffer writer
- px_addr  out  ADDR_W  framebuffer address = y*SCR_W + x
- px_data  out  DATA_W  pixel colour

Behaviour:
- Reset values: busy=0, done=0, px_valid=0, rom_addr=0, px_addr=0, px_data=0, state=IDLE, all counters 0.
- Reset is asynchronous at any time, including mid-blit: in-flight ROM reads and buffered pixels are discarded, and no done pulse is produced.
- States:
  - IDLE: start=1 latches pos_x, pos_y and frame base, then goes to FETCH.
  - FETCH: issues reads.
  - DRAIN: waits for the read pipe and skid buffer to empty.
  - DONE: pulses done for one cycle, then returns to IDLE.
- Frame base = frame_sel*SPR_W*SPR_H. If frame_sel >= NUM_FRAMES, frame 0 is used.
- Addressing: col and row counters plus a linear ROM address counter (no multiplier in the loop).
  - col wraps at SPR_W-1 and row increments.
  - After col=SPR_W-1, row=SPR_H-1 is issued, FETCH goes to DRAIN.
- Read issue: a read is issued in a FETCH cycle only if (skid occupancy + reads in flight) < 2.
  - A 2-entry skid FIFO guarantees no pixel is lost under backpressure; rom_data is captured unconditionally 1 cycle after issue.
  - With px_ready held high, throughput is 1 pixel/cycle.
- Each read carries its dest x = pos_x+col and y = pos_y+row (11-bit, no wrap).
  - If x >= SCR_W or y >= SCR_H, the returned pixel is dropped: it is not written to the FIFO and not emitted.
- Output:
  - px_valid = FIFO non-empty.
  - Transfer occurs when px_valid & px_ready.
  - px_addr and px_data stay stable while px_valid=1 and px_ready=0.
- Simultaneous FIFO push and pop in the same cycle is legal; occupancy is unchanged.
- DRAIN goes to DONE when reads in flight = 0 and the FIFO is empty.
- done asserts the cycle after the last pixel transfer, or the cycle after the last read returns if all pixels were clipped.
- start while busy=1 is ignored. start in the DONE cycle is also ignored.
- A fully offscreen sprite still walks all SPR_W*SPR_H addresses and emits 0 pixels.

Optional Feature:
- Macro SPRITE_BLIT_TRANSPARENT_EN.
- Defined: returned pixels equal to KEY_COLOR are dropped in the same way as clipped pixels.
- Undefined: every on-screen pixel is emitted, including KEY_COLOR.

Decomposition:
- Shared package sprite_pkg holds:
  - typedef pixel_t (logic [23:0])
  - typedef fb_addr_t (logic [18:0])
  - constants SCR_W, SCR_H, KEY_COLOR
  - enum blit_state_t {IDLE, FETCH, DRAIN, DONE}
- Sub-module blit_skid_fifo: a 2-entry FIFO of {fb_addr_t, pixel_t} with push, pop, full and empty.

Test Plan:
- Basic blit: pos=(100,50), frame 0, px_ready=1.
  - Required: exactly 1140 pixels.
  - First px_addr = 50*640+100 = 32100, px_data = ROM[0].
  - Last px_addr = 79*640+137 = 50697.
  - done pulses once; total latency ≤ 1140+4 cycles.
- Backpressure: px_ready toggles 1,0,0,1 repeatedly.
  - Required: the pixel sequence is identical to the basic blit, with no drops or duplicates.
  - px_addr and px_data hold steady while stalled.
- Right-edge clip: pos=(620,0).
  - Required: only columns 0..19 are emitted, giving 20*30 = 600 pixels; done still pulses.
- Fully offscreen: pos=(700,500).
  - Required: 0 px_valid cycles, 1140 ROM reads, done pulses.
- Reset mid-blit: assert Reset_n=0 after 200 pixels.
  - Required: all outputs go to reset values immediately, and there is no done pulse.
  - A new start then produces a clean full blit.
- Transparency (macro defined): ROM contains 300 words equal to 24'hFF00FF.
  - Required: 840 pixels emitted.
  - Macro undefined: 1140 pixels emitted.
